// File: rtl/onehot_encoder.sv
// Registered one-hot to binary encoder with valid/ready handshake and a
// saturating count of malformed input words.
module onehot_encoder #(
   parameter int unsigned N          = 4,
   parameter int unsigned W          = $clog2(N),
   parameter bit          ACTIVE_LOW = 1'b0,
   parameter bit          PRIORITY   = 1'b0,
   parameter int unsigned CNT_W      = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N-1:0]     in_word,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [W-1:0]     out_code,
   output logic             out_err,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             err_clr,
   output logic [CNT_W-1:0] err_count
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [W-1:0]     code_q, code_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [N-1:0]     norm_w;
   logic             hit;
   logic             multi;
   logic [W-1:0]     idx;
   logic [W-1:0]     dec_code;
   logic             dec_err;
   logic             accept;

   // Decode: idx ends on the highest set lane; multi flags a second set lane.
   always_comb begin
      norm_w = ACTIVE_LOW ? ~in_word : in_word;
      hit    = 1'b0;
      multi  = 1'b0;
      idx    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (norm_w[i]) begin
            multi = multi | hit;
            hit   = 1'b1;
            idx   = W'(i);
         end
      end
      if (PRIORITY) begin
         dec_err = ~hit;
      end else begin
         dec_err = ~hit | multi;
      end
      dec_code = dec_err ? '0 : idx;
   end

   // Ready passes out_ready through while full; held low during reset.
   assign in_ready = rst_n & ((state_q == EMPTY) | out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      case (state_q)
         EMPTY: begin
            if (accept) state_d = FULL;
         end
         FULL: begin
            if (out_ready && !in_valid) state_d = EMPTY;
         end
         default: state_d = EMPTY;
      endcase

      if (accept) begin
         code_d = dec_code;
         err_d  = dec_err;
      end

      // Clear wins over a coincident increment; counter saturates.
      if (err_clr) begin
         cnt_d = '0;
      end else if (accept && dec_err && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         code_q  <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign out_valid = (state_q == FULL);
   assign out_code  = code_q;
   assign out_err   = err_q;
   assign err_count = cnt_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// Bench for onehot_encoder: strict, priority and active-low instances share
// the same stimulus; each is checked against its own hand-computed column.
module tb_onehot_encoder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_word;
   logic       in_valid;
   logic       out_ready;
   logic       err_clr;

   logic [1:0] code_o  [3];
   logic       err_o   [3];
   logic       valid_o [3];
   logic       rdy_o   [3];
   logic [7:0] cnt_o   [3];

   int pass_cnt = 0;
   int tot_cnt  = 0;

   logic [1:0] got_q[$];

   always #5 clk = ~clk;

   onehot_encoder #(.N(4), .W(2), .ACTIVE_LOW(1'b0), .PRIORITY(1'b0), .CNT_W(8)) u_strict (
      .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .in_ready(rdy_o[0]),
      .out_code(code_o[0]), .out_err(err_o[0]), .out_valid(valid_o[0]), .out_ready(out_ready),
      .err_clr(err_clr), .err_count(cnt_o[0]));

   onehot_encoder #(.N(4), .W(2), .ACTIVE_LOW(1'b0), .PRIORITY(1'b1), .CNT_W(8)) u_prio (
      .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .in_ready(rdy_o[1]),
      .out_code(code_o[1]), .out_err(err_o[1]), .out_valid(valid_o[1]), .out_ready(out_ready),
      .err_clr(err_clr), .err_count(cnt_o[1]));

   onehot_encoder #(.N(4), .W(2), .ACTIVE_LOW(1'b1), .PRIORITY(1'b0), .CNT_W(8)) u_alow (
      .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid), .in_ready(rdy_o[2]),
      .out_code(code_o[2]), .out_err(err_o[2]), .out_valid(valid_o[2]), .out_ready(out_ready),
      .err_clr(err_clr), .err_count(cnt_o[2]));

   // Delivered codes of the strict instance; handshake values are stable at negedge.
   always @(negedge clk) begin
      if (rst_n && valid_o[0] && out_ready) got_q.push_back(code_o[0]);
   end

   typedef struct packed {
      logic [3:0]      word;
      logic [2:0][1:0] code;
      logic [2:0]      err;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] w,
                               input logic [1:0] c0, input logic e0,
                               input logic [1:0] c1, input logic e1,
                               input logic [1:0] c2, input logic e2);
      vec_t v;
      v.word    = w;
      v.code[0] = c0; v.err[0] = e0;
      v.code[1] = c1; v.err[1] = e1;
      v.code[2] = c2; v.err[2] = e2;
      return v;
   endfunction

   task automatic chk(input string nm, input int act, input int exp);
      tot_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   vec_t vecs[10];
   int   exp_cnt[3];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      // columns: strict | priority | active-low strict
      vecs[0] = mk(4'b0001, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
      vecs[1] = mk(4'b0010, 2'd1, 1'b0, 2'd1, 1'b0, 2'd0, 1'b1);
      vecs[2] = mk(4'b0100, 2'd2, 1'b0, 2'd2, 1'b0, 2'd0, 1'b1);
      vecs[3] = mk(4'b1000, 2'd3, 1'b0, 2'd3, 1'b0, 2'd0, 1'b1);
      vecs[4] = mk(4'b0000, 2'd0, 1'b1, 2'd0, 1'b1, 2'd0, 1'b1);
      vecs[5] = mk(4'b0110, 2'd0, 1'b1, 2'd2, 1'b0, 2'd0, 1'b1);
      vecs[6] = mk(4'b1011, 2'd0, 1'b1, 2'd3, 1'b0, 2'd2, 1'b0);
      vecs[7] = mk(4'b1111, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b1);
      vecs[8] = mk(4'b1110, 2'd0, 1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
      vecs[9] = mk(4'b0111, 2'd0, 1'b1, 2'd2, 1'b0, 2'd3, 1'b0);

      rst_n = 1'b0; in_word = '0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
      #1;
      chk("reset_in_ready", int'(rdy_o[0]), 0);
      #20;
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("post_reset_in_ready[%0d]", k), int'(rdy_o[k]), 1);
         chk($sformatf("post_reset_valid[%0d]", k), int'(valid_o[k]), 0);
         chk($sformatf("post_reset_code[%0d]", k), int'(code_o[k]), 0);
         chk($sformatf("post_reset_err[%0d]", k), int'(err_o[k]), 0);
         chk($sformatf("post_reset_cnt[%0d]", k), int'(cnt_o[k]), 0);
         exp_cnt[k] = 0;
      end

      // Back-to-back table: one word per clock with out_ready held high.
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         in_word  = vecs[i].word;
         in_valid = 1'b1;
         tick();
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("vec%0d_valid[%0d]", i, k), int'(valid_o[k]), 1);
            chk($sformatf("vec%0d_code[%0d]", i, k), int'(code_o[k]), int'(vecs[i].code[k]));
            chk($sformatf("vec%0d_err[%0d]", i, k), int'(err_o[k]), int'(vecs[i].err[k]));
            exp_cnt[k] += int'(vecs[i].err[k]);
         end
      end
      in_valid = 1'b0;
      in_word  = 4'b1010;
      tick();
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("drain_valid[%0d]", k), int'(valid_o[k]), 0);
         chk($sformatf("drain_code_held[%0d]", k), int'(code_o[k]), int'(vecs[9].code[k]));
         chk($sformatf("table_err_count[%0d]", k), int'(cnt_o[k]), exp_cnt[k]);
      end

      // Backpressure: A accepted, then B offered for 5 stalled clocks.
      got_q.delete();
      in_word = 4'b0001; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_word = 4'b0010; out_ready = 1'b0;
      #1;
      chk("bp_in_ready_comb", int'(rdy_o[0]), 0);
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("bp%0d_in_ready", c), int'(rdy_o[0]), 0);
         chk($sformatf("bp%0d_valid", c), int'(valid_o[0]), 1);
         chk($sformatf("bp%0d_code_held", c), int'(code_o[0]), 0);
      end
      out_ready = 1'b1;
      tick();
      chk("bp_release_code", int'(code_o[0]), 1);
      in_valid = 1'b0;
      tick();
      chk("bp_drain_valid", int'(valid_o[0]), 0);
      chk("bp_delivered_count", got_q.size(), 2);
      if (got_q.size() == 2) begin
         chk("bp_order_first", int'(got_q[0]), 0);
         chk("bp_order_second", int'(got_q[1]), 1);
      end

      // Saturation: 300 malformed words (0000 is malformed for every instance).
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      for (int k = 0; k < 3; k++) chk($sformatf("clr_idle_cnt[%0d]", k), int'(cnt_o[k]), 0);
      in_word = 4'b0000; in_valid = 1'b1;
      repeat (300) tick();
      in_valid = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) chk($sformatf("sat_cnt[%0d]", k), int'(cnt_o[k]), 255);
      in_valid = 1'b1; err_clr = 1'b1;
      tick();
      in_valid = 1'b0; err_clr = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("clr_vs_inc_cnt[%0d]", k), int'(cnt_o[k]), 0);
         chk($sformatf("clr_vs_inc_err[%0d]", k), int'(err_o[k]), 1);
      end

      // Reset asserted mid-FULL with a stalled consumer.
      tick();
      in_word = 4'b0000; in_valid = 1'b1; out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("pre_rst_valid", int'(valid_o[0]), 1);
      chk("pre_rst_cnt", int'(cnt_o[0]), 1);
      #2;
      rst_n = 1'b0;
      in_valid = 1'b1;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("mid_rst_valid[%0d]", k), int'(valid_o[k]), 0);
         chk($sformatf("mid_rst_cnt[%0d]", k), int'(cnt_o[k]), 0);
         chk($sformatf("mid_rst_in_ready[%0d]", k), int'(rdy_o[k]), 0);
      end
      tick();
      chk("rst_held_in_ready", int'(rdy_o[0]), 0);
      chk("rst_held_valid", int'(valid_o[0]), 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("rel_in_ready", int'(rdy_o[0]), 1);
      chk("rel_no_emit", int'(valid_o[0]), 0);
      tick();
      chk("rel_no_emit_late", int'(valid_o[0]), 0);

      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end

endmodule
